ws2812_frame_tx: RTL and testbench

//  Streams one frame of NUM_LEDS 24-bit GRB words from the pixel buffer RAM onto a NeoPixel data line.

---
 rtl/ws2812_frame_tx.sv | 157 +++++++++++++++
 tb/tb_ws2812_frame_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: fetches NUM_LEDS GRB words from the pixel RAM and
// serialises them MSB-first with WS2812 bit timing, then holds the latch period.
module ws2812_frame_tx #(
  parameter int unsigned NUM_LEDS     = 256,
  parameter int unsigned SYSTEM_CLOCK = 100_000_000,
  parameter int unsigned T0H_NS       = 400,
  parameter int unsigned T1H_NS       = 800,
  parameter int unsigned BIT_NS       = 1250,
  parameter int unsigned RESET_US     = 80,
  parameter int unsigned ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [23:0]       rd_data_i,
  output logic              do_o,
  output logic              ws_bsy_o,
  output logic              done_o
);

  localparam int unsigned T0H_C = (SYSTEM_CLOCK / 1000) * T0H_NS / 1_000_000;
  localparam int unsigned T1H_C = (SYSTEM_CLOCK / 1000) * T1H_NS / 1_000_000;
  localparam int unsigned BIT_C = (SYSTEM_CLOCK / 1000) * BIT_NS / 1_000_000;
  localparam int unsigned RST_C = (SYSTEM_CLOCK / 1_000_000) * RESET_US;

  localparam int unsigned CNT_W = (BIT_C > 1) ? $clog2(BIT_C) : 1;
  localparam int unsigned LAT_W = (RST_C > 1) ? $clog2(RST_C) : 1;

  localparam logic [CNT_W-1:0]  T0H_V    = CNT_W'(T0H_C);
  localparam logic [CNT_W-1:0]  T1H_V    = CNT_W'(T1H_C);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(BIT_C - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RST_C - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_LEDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  generate
    if (!(T0H_C > 0 && T0H_C < T1H_C && T1H_C < BIT_C && RST_C > 0 && NUM_LEDS > 0)) begin : g_bad_timing
      $error("ws2812_frame_tx: timing parameters must satisfy 0 < T0H_C < T1H_C < BIT_C");
    end
  endgenerate

  logic [2:0]        state_r, state_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [4:0]        bit_r, bit_n;
  logic [ADDR_W-1:0] pix_r, pix_n;
  logic [LAT_W-1:0]  lat_r, lat_n;
  logic [23:0]       shift_r, shift_n;
  logic [23:0]       next_r, next_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              do_n, bsy_n, done_n;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      bit_r     <= '0;
      pix_r     <= '0;
      lat_r     <= '0;
      shift_r   <= '0;
      next_r    <= '0;
      rd_addr_o <= '0;
      do_o      <= 1'b0;
      ws_bsy_o  <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_r     <= bit_n;
      pix_r     <= pix_n;
      lat_r     <= lat_n;
      shift_r   <= shift_n;
      next_r    <= next_n;
      rd_addr_o <= rd_addr_n;
      do_o      <= do_n;
      ws_bsy_o  <= bsy_n;
      done_o    <= done_n;
    end
  end

  // Next-state logic; outputs are derived from next-cycle values so they register cleanly
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_n     = bit_r;
    pix_n     = pix_r;
    lat_n     = lat_r;
    shift_n   = shift_r;
    next_n    = next_r;
    rd_addr_n = rd_addr_o;
    done_n    = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (start_i) state_n = S_FETCH;
      end
      S_FETCH: begin
        state_n = S_LOAD;
      end
      S_LOAD: begin
        shift_n = rd_data_i;
        bit_n   = 5'd23;
        pix_n   = '0;
        cnt_n   = '0;
        state_n = S_SEND;
      end
      S_SEND: begin
        // Prefetched word arrives one cycle after the address is presented
        if (bit_r == 5'd23 && cnt_r == CNT_W'(1)) next_n = rd_data_i;
        if (cnt_r == BIT_LAST) begin
          cnt_n = '0;
          if (bit_r != 5'd0) begin
            bit_n   = bit_r - 5'd1;
            shift_n = {shift_r[22:0], 1'b0};
          end else if (pix_r != PIX_LAST) begin
            bit_n   = 5'd23;
            shift_n = next_r;
            pix_n   = pix_r + ADDR_W'(1);
          end else begin
            lat_n   = '0;
            state_n = S_LATCH;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (lat_r == LAT_LAST) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          lat_n = lat_r + LAT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Present the next pixel's address on the first cycle of each pixel's MSB
    if (state_n == S_SEND && bit_n == 5'd23 && cnt_n == '0 &&
        (32'(pix_n) + 32'd1) < NUM_LEDS) begin
      rd_addr_n = pix_n + ADDR_W'(1);
    end
    if (state_n == S_IDLE || state_n == S_FETCH) rd_addr_n = '0;

    do_n  = (state_n == S_SEND) && (cnt_n < (shift_n[23] ? T1H_V : T0H_V));
    bsy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: random pixel data, waveform checked against an
// arithmetic model of the WS2812 stream and decoded back to pixel words.
module tb_ws2812_frame_tx;

  localparam int NL      = 2;
  localparam int BIT_C   = 125;
  localparam int T0H     = 40;
  localparam int T1H     = 80;
  localparam int RST_C   = 8000;
  localparam int SEND_C  = NL * 24 * BIT_C;
  localparam int FRAME_C = SEND_C + RST_C;

  logic        clk_i    = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i  = 1'b0;
  logic [0:0]  rd_addr_o;
  logic [23:0] rd_data_i = '0;
  logic        do_o;
  logic        ws_bsy_o;
  logic        done_o;

  logic [23:0] ram [NL];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int done_total = 0;

  ws2812_frame_tx #(.NUM_LEDS(NL)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .start_i   (start_i),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .do_o      (do_o),
    .ws_bsy_o  (ws_bsy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Pixel RAM with one cycle read latency, plus cycle and done counters
  always @(posedge clk_i) begin
    cyc       <= cyc + 1;
    rd_data_i <= ram[rd_addr_o];
    if (done_o) done_total <= done_total + 1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Expected line level t cycles after the first rise of a frame
  function automatic bit model_do(input logic [47:0] frame, input int t);
    if (t >= SEND_C) return 1'b0;
    return (t % BIT_C) < (frame[47 - t / BIT_C] ? T1H : T0H);
  endfunction

  // Starts a frame at the current negedge and follows it to done_o
  task automatic run_frame(input string tag, input bit hold, input bit poke);
    logic [47:0] exp;
    logic [47:0] dec;
    int s, r, dn, mism, hi, addr_p0, bsy_pre, bsy_dn;
    exp = {ram[0], ram[1]};
    s = cyc;
    chk({tag, "_bsy_idle"}, ws_bsy_o, 0);
    start_i = 1'b1;
    @(negedge clk_i);
    if (!hold) start_i = 1'b0;
    chk({tag, "_bsy_on"}, ws_bsy_o, 1);
    chk({tag, "_done_clr"}, done_o, 0);
    for (int i = 0; i < 8 && !do_o; i++) @(negedge clk_i);
    chk({tag, "_rise_seen"}, do_o, 1);
    if (!do_o) return;
    r = cyc;
    chk({tag, "_rise_lat"}, r - s, 3);
    dec = '0; mism = 0; hi = 0; dn = -1; addr_p0 = -1; bsy_pre = -1; bsy_dn = -1;
    for (int t = 0; t <= FRAME_C + 4; t++) begin
      if (t > 0) @(negedge clk_i);
      if (do_o !== model_do(exp, t)) mism++;
      if (t < SEND_C) begin
        if (t % BIT_C == 0) hi = 0;
        hi += int'(do_o);
        if (t % BIT_C == BIT_C - 1) dec = {dec[46:0], hi > (T0H + T1H) / 2};
      end
      if (t == 2) addr_p0 = int'(rd_addr_o);
      if (t == FRAME_C - 1) bsy_pre = int'(ws_bsy_o);
      if (poke && (t == 1000 || t == 9000)) start_i = 1'b1;
      if (poke && (t == 1001 || t == 9001)) start_i = 1'b0;
      if (done_o) begin
        dn = t;
        bsy_dn = int'(ws_bsy_o);
        break;
      end
    end
    chk({tag, "_done_at"}, dn, FRAME_C);
    chk({tag, "_wave_mism"}, mism, 0);
    chk({tag, "_decoded"}, dec, exp);
    chk({tag, "_prefetch_addr"}, addr_p0, 1);
    chk({tag, "_bsy_latch"}, bsy_pre, 1);
    chk({tag, "_bsy_at_done"}, bsy_dn, 0);
  endtask

  task automatic after_frame(input string tag);
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_addr_idle"}, rd_addr_o, 0);
  endtask

  initial begin
    int dn_before;
    ram[0] = 24'hFF0000;
    ram[1] = 24'h00A501;
    repeat (3) @(negedge clk_i);
    chk("rst_do", do_o, 0);
    chk("rst_bsy", ws_bsy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr", rd_addr_o, 0);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Known pattern, with start pulses mid-SEND and mid-LATCH that must be dropped
    run_frame("fix", 1'b0, 1'b1);
    after_frame("fix");
    repeat (5) @(negedge clk_i);
    chk("fix_bsy_after", ws_bsy_o, 0);
    chk("fix_done_count", done_total, 1);

    ram[0] = 24'($urandom);
    ram[1] = 24'($urandom);
    run_frame("rnd", 1'b0, 1'b0);
    after_frame("rnd");

    // Abort mid bit 10 while the line is high
    ram[0] = 24'($urandom);
    ram[1] = 24'($urandom);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 8 && !do_o; i++) @(negedge clk_i);
    repeat (10 * BIT_C + 20) @(negedge clk_i);
    chk("abort_do_high", do_o, 1);
    dn_before = done_total;
    #2 reset_ni = 1'b0;
    #1;
    chk("abort_do", do_o, 0);
    chk("abort_bsy", ws_bsy_o, 0);
    chk("abort_addr", rd_addr_o, 0);
    repeat (20) @(negedge clk_i);
    chk("abort_no_done", done_total, dn_before);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // start held high: back-to-back frames, each rising 3 cycles after the prior done
    ram[0] = 24'($urandom);
    ram[1] = 24'($urandom);
    run_frame("b2b0", 1'b1, 1'b0);
    ram[0] = 24'($urandom);
    ram[1] = 24'($urandom);
    run_frame("b2b1", 1'b1, 1'b0);
    start_i = 1'b0;
    after_frame("b2b1");
    repeat (10) @(negedge clk_i);
    chk("end_bsy", ws_bsy_o, 0);
    chk("end_done_count", done_total, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
